// File: rtl/pwm_sample_feeder_if.sv
// rtl/pwm_sample_feeder_if.sv - sample stream handshake between producer and PWM sample feeder
interface pwm_sample_feeder_if #(
    parameter int THRESHOLD_NBITS = 4
);
    logic [THRESHOLD_NBITS-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/pwm_sample_feeder.sv
// rtl/pwm_sample_feeder.sv - buffers duty-cycle samples and feeds one per PWM period to the threshold
module pwm_sample_feeder #(
    parameter int THRESHOLD_NBITS = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pwm_sample_feeder_if.slave           s,
    input  logic                         period_start,
    input  logic                         run,
    input  logic                         underrun_clr,
    output logic [THRESHOLD_NBITS-1:0]   threshold,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [THRESHOLD_NBITS-1:0] thr_nxt;
    logic [THRESHOLD_NBITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]              rd_ptr;
    logic [AW-1:0]              wr_ptr;
    logic                       wr_en;
    logic                       pop;
    logic                       ur_evt;
    logic                       fifo_empty;

    // Ready depends only on the stored level, so a full FIFO refuses a write
    // even when a pop happens in the same cycle.
    assign s.s_ready  = (fifo_level < DEPTH_L);
    assign wr_en      = s.s_valid & s.s_ready;
    assign fifo_empty = (fifo_level == '0);

    // Sample storage; contents need no reset because level and pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s.s_data;
        end
    end

    // Pointers and level; emptiness is judged before this cycle's write, so a
    // sample arriving with period_start is never popped in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Playback state, threshold register and sticky underrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            threshold <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            threshold <= thr_nxt;
            if (ur_evt) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // Next-state and pop decision; threshold only moves on period_start or when playback stops.
    always_comb begin
        state_nxt = state;
        thr_nxt   = threshold;
        pop       = 1'b0;
        ur_evt    = 1'b0;
        case (state)
            IDLE: begin
                thr_nxt = '0;
                if (run) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                if (!run) begin
                    state_nxt = IDLE;
                    thr_nxt   = '0;
                end else if (period_start && !fifo_empty) begin
                    pop       = 1'b1;
                    thr_nxt   = mem[rd_ptr];
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (!run) begin
                    state_nxt = IDLE;
                    thr_nxt   = '0;
                end else if (period_start) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        thr_nxt = mem[rd_ptr];
                    end else begin
                        ur_evt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                thr_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// tb/tb_pwm_sample_feeder.sv - self-checking bench for pwm_sample_feeder
module tb_pwm_sample_feeder;

    localparam int TN   = 4;
    localparam int D    = 4;
    localparam int MAXV = (1 << TN) - 1;

    logic                   clk          = 1'b0;
    logic                   rst_n        = 1'b1;
    logic                   period_start = 1'b0;
    logic                   run          = 1'b0;
    logic                   underrun_clr = 1'b0;
    logic [TN-1:0]          threshold;
    logic [$clog2(D):0]     fifo_level;
    logic                   underrun;

    pwm_sample_feeder_if #(.THRESHOLD_NBITS(TN)) sif ();

    always #5 clk = ~clk;

    pwm_sample_feeder #(
        .THRESHOLD_NBITS(TN),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (sif),
        .period_start(period_start),
        .run         (run),
        .underrun_clr(underrun_clr),
        .threshold   (threshold),
        .fifo_level  (fifo_level),
        .underrun    (underrun)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of buffered samples plus playback flags.
    int q[$];
    int m_thr     = 0;
    bit m_armed   = 1'b0;
    bit m_started = 1'b0;
    bit m_ur      = 1'b0;

    task automatic chk(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":threshold"}, int'(threshold), m_thr);
        chk({tag, ":level"}, int'(fifo_level), q.size());
        chk({tag, ":underrun"}, int'(underrun), int'(m_ur));
        chk({tag, ":ready"}, int'(sif.s_ready), (q.size() < D) ? 1 : 0);
    endtask

    task automatic cyc(input bit v, input int d, input bit ps, input bit r, input bit clr, input string tag);
        bit acc;
        bit ev;
        sif.s_valid  = v;
        sif.s_data   = d[TN-1:0];
        period_start = ps;
        run          = r;
        underrun_clr = clr;
        acc = v && (q.size() < D);
        ev  = 1'b0;
        if (!m_armed) begin
            m_thr   = 0;
            m_armed = r;
        end else if (!r) begin
            m_armed   = 1'b0;
            m_started = 1'b0;
            m_thr     = 0;
        end else if (ps) begin
            if (q.size() > 0) begin
                m_thr     = q.pop_front();
                m_started = 1'b1;
            end else if (m_started) begin
                ev = 1'b1;
            end
        end
        if (acc) q.push_back(d);
        if (ev) m_ur = 1'b1;
        else if (clr) m_ur = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        sif.s_valid  = 1'b0;
        sif.s_data   = '0;
        period_start = 1'b0;
        run          = 1'b0;
        underrun_clr = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, ":threshold"}, int'(threshold), 0);
        chk({tag, ":level"}, int'(fifo_level), 0);
        chk({tag, ":underrun"}, int'(underrun), 0);
        chk({tag, ":ready"}, int'(sif.s_ready), 1);
        q.delete();
        m_thr     = 0;
        m_armed   = 1'b0;
        m_started = 1'b0;
        m_ur      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, "_release"});
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;

        do_reset("rst0");

        // Priming with an empty FIFO: threshold stays 0, no underrun.
        cyc(0, 0, 0, 1, 0, "arm");
        repeat (3) begin
            cyc(0, 0, 1, 1, 0, "prime_ps");
            cyc(0, 0, 0, 1, 0, "prime_gap");
        end
        chk("prime_thr", int'(threshold), 0);
        chk("prime_ur", int'(underrun), 0);
        cyc(1, 5, 0, 1, 0, "wr5");
        cyc(0, 0, 0, 1, 0, "wr5_gap");
        chk("hold_before_ps", int'(threshold), 0);
        cyc(0, 0, 1, 1, 0, "load5");
        chk("load5_direct", int'(threshold), 5);
        cyc(0, 0, 1, 1, 0, "play_empty");
        chk("play_empty_ur", int'(underrun), 1);
        chk("play_empty_hold", int'(threshold), 5);
        cyc(0, 0, 0, 1, 1, "clr0");

        // Fill with run low, then backpressure.
        cyc(0, 0, 0, 0, 0, "stop");
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0, 0, "fill");
        chk("full_level", int'(fifo_level), 4);
        chk("full_ready", int'(sif.s_ready), 0);
        cyc(1, 11, 0, 0, 0, "fill_rejected");
        chk("full_level_after", int'(fifo_level), 4);
        cyc(0, 0, 0, 1, 0, "arm2");
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 1, 1, 0, "drain");
            chk("drain_seq", int'(threshold), i);
            cyc(0, 0, 0, 1, 0, "drain_gap");
        end

        // Underrun and set-wins-over-clear.
        cyc(1, 7, 0, 1, 0, "wr7");
        cyc(0, 0, 1, 1, 0, "load7");
        cyc(0, 0, 1, 1, 0, "ur7");
        chk("ur7_thr", int'(threshold), 7);
        chk("ur7_flag", int'(underrun), 1);
        cyc(0, 0, 1, 1, 1, "clr_vs_set");
        chk("clr_vs_set_flag", int'(underrun), 1);
        cyc(0, 0, 0, 1, 1, "clr1");
        chk("clr1_flag", int'(underrun), 0);

        // Simultaneous write and pop.
        cyc(1, 3, 0, 1, 0, "wr3");
        cyc(1, 6, 0, 1, 0, "wr6");
        cyc(1, 9, 1, 1, 0, "wr9_pop");
        chk("simul_level", int'(fifo_level), 2);
        chk("simul_thr", int'(threshold), 3);

        // Pointer wrap with random traffic.
        repeat (3 * D * 4) cyc($urandom_range(0, 1) != 0, int'($urandom_range(0, MAXV)),
                               $urandom_range(0, 1) != 0, 1, 0, "wrap");
        repeat (D + 1) cyc(0, 0, 1, 1, 0, "wrap_drain");
        cyc(0, 0, 0, 1, 1, "clr2");

        // Boundary values pass unmodified.
        cyc(1, 0, 0, 1, 0, "wr_min");
        cyc(1, MAXV, 0, 1, 0, "wr_max");
        cyc(0, 0, 1, 1, 0, "pop_min");
        chk("min_thr", int'(threshold), 0);
        cyc(0, 0, 1, 1, 0, "pop_max");
        chk("max_thr", int'(threshold), MAXV);

        // Run drop keeps buffered samples.
        for (int i = 0; i < 3; i++) cyc(1, int'($urandom_range(1, MAXV)), 0, 1, 0, "buf3");
        cyc(0, 0, 0, 0, 0, "run_drop");
        chk("run_drop_thr", int'(threshold), 0);
        chk("run_drop_level", int'(fifo_level), 3);

        // Reset mid-cycle flushes everything; no stale sample afterwards.
        do_reset("rst1");
        cyc(0, 0, 0, 1, 0, "arm3");
        cyc(0, 0, 1, 1, 0, "post_rst_ps");
        chk("post_rst_thr", int'(threshold), 0);
        chk("post_rst_ur", int'(underrun), 0);

        // Random soak across all inputs.
        repeat (300) cyc($urandom_range(0, 2) != 0, int'($urandom_range(0, MAXV)),
                         $urandom_range(0, 2) == 0, $urandom_range(0, 15) != 0,
                         $urandom_range(0, 7) == 0, "soak");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_sample_feeder.md
PWM_SAMPLE_FEEDER -- requirements
Module: pwm_sample_feeder

Interface
REQ-001 The block SHALL have parameter THRESHOLD_NBITS, default 4, giving the sample/threshold width; it matches the downstream PWM threshold width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the sample buffer depth; legal values are powers of 2, minimum 2.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; every flop in the block is clocked by its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port s_data, input, THRESHOLD_NBITS, the duty-cycle sample from the producer.
REQ-006 The block SHALL have port s_valid, input, 1, which qualifies s_data.
REQ-007 The block SHALL have port s_ready, output, 1, asserted while the FIFO can accept a sample.
REQ-008 The block SHALL have port period_start, input, 1, a single-cycle pulse at each PWM counter wrap.
REQ-009 The block SHALL have port run, input, 1, the playback enable.
REQ-010 The block SHALL have port underrun_clr, input, 1, which clears the sticky underrun flag.
REQ-011 The block SHALL have port threshold, output, THRESHOLD_NBITS, the registered duty-cycle value driven to the PWM threshold input.
REQ-012 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, the number of samples currently stored.
REQ-013 The block SHALL have port underrun, output, 1, a sticky flag indicating a missed sample.

Function
REQ-014 The FIFO SHALL be a circular buffer with wrapping read and write pointers and a separate level counter.
- Write: s_valid & s_ready.
- s_ready = (fifo_level < FIFO_DEPTH).
- s_ready is combinational from the level only and never depends on s_valid.
REQ-015 When the FIFO is full, a write SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-016 The FSM SHALL have exactly the states IDLE, PRIME and PLAY.
REQ-017 IDLE behaviour:
- threshold is loaded with 0.
- No pops occur; writes are still accepted.
- run=1 -> PRIME.
REQ-018 PRIME behaviour:
- On period_start with FIFO non-empty: pop the head into threshold, go to PLAY.
- On period_start with FIFO empty: hold threshold at 0, set no flag, stay in PRIME.
REQ-019 PLAY behaviour:
- On period_start with FIFO non-empty: pop the head into threshold.
- On period_start with FIFO empty: hold the previous threshold, set underrun, stay in PLAY.
REQ-020 run=0 in PRIME or PLAY SHALL force the state to IDLE and threshold to 0 on the next edge; stored samples are retained.
REQ-021 threshold SHALL change only on the clock edge at which period_start=1 is sampled, giving 1-cycle latency so the PWM sees the new value from the first count of the next period.
REQ-022 threshold SHALL hold between period_start pulses regardless of FIFO writes.
REQ-023 A simultaneous write and pop SHALL leave fifo_level unchanged; pointers advance independently modulo FIFO_DEPTH.
REQ-024 If the FIFO is empty and a write coincides with period_start, the pop SHALL NOT take the incoming sample: PLAY records an underrun, PRIME stays in PRIME, and the sample is stored.
REQ-025 underrun_clr=1 SHALL clear underrun on the next edge unless a new underrun event occurs in the same cycle; set wins.
REQ-026 period_start SHALL be ignored in any cycle where run=0.

Reset
REQ-027 While rst_n=0 the block SHALL asynchronously force the following, and SHALL hold them until the first rising clk edge after rst_n rises:
- state=IDLE, threshold=0, fifo_level=0, pointers=0, underrun=0;
- s_ready=1 during and after reset.
REQ-028 Reset asserted mid-playback SHALL flush all buffered samples, and no stale sample SHALL appear on threshold after release.

Verification
REQ-029 The bench SHALL cover reset and priming:
- Reset, run=1, no writes, 3 period_start pulses -> threshold=0, state PRIME, underrun=0.
- Then write 5 -> next period_start loads threshold=5 one cycle later, state PLAY.
REQ-030 The bench SHALL cover fill and backpressure: write 1,2,3,4 with run=0 -> fifo_level=4, s_ready=0; a 5th s_valid is not accepted.
- Then run=1 with 4 periods -> threshold sequence 1,2,3,4.
REQ-031 The bench SHALL cover underrun: in PLAY with threshold=7 and FIFO empty, period_start -> threshold stays 7 and underrun=1.
- underrun_clr coincident with a second empty period_start -> underrun stays 1.
REQ-032 The bench SHALL cover a simultaneous write and pop: fifo_level=2, write 9 with period_start in the same cycle -> fifo_level stays 2 and threshold = old head.
- Pointer wrap is exercised over at least 3*FIFO_DEPTH samples with no reordering.
REQ-033 The bench SHALL cover run drop and reset: in PLAY with 3 samples buffered, run=0 -> threshold=0 next edge, fifo_level=3.
- rst_n pulsed low asynchronously mid-cycle -> all outputs at reset values immediately, fifo_level=0.
REQ-034 The bench SHALL cover the boundary values: samples 0 and 2^THRESHOLD_NBITS-1 pass to threshold unmodified.
